// File: rtl/collision_scheduler.sv
// collision_scheduler: walks the alien formation one slot per clock with a
// single shared box comparator and reports the lowest-index slot whose box
// contains the player projectile tip. Slot coordinates come from incremental
// adders; all scan inputs are snapshotted when a request is accepted.
module collision_scheduler #(
   parameter int COLS    = 11,
   parameter int ROWS    = 5,
   parameter int X_W     = 10,
   parameter int Y_W     = 10,
   parameter int IDX_W   = 6,
   parameter int ALIEN_W = 16,
   parameter int ALIEN_H = 8,
   parameter int SPACE_X = 24,
   parameter int SPACE_Y = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clk_collision,
   input  logic [X_W-1:0]        grid_x,
   input  logic [Y_W-1:0]        grid_y,
   input  logic [ROWS*COLS-1:0]  alive,
   input  logic                  proj_valid,
   input  logic [X_W-1:0]        proj_x,
   input  logic [Y_W-1:0]        proj_y,
   output logic                  busy,
   output logic                  done,
   output logic                  hit,
   output logic [IDX_W-1:0]      hit_index
);

   localparam int N     = ROWS * COLS;
   localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t            state_reg;
   logic [N-1:0]      alive_snap;
   logic [X_W-1:0]    px_snap;
   logic [Y_W-1:0]    py_snap;
   logic [X_W:0]      grid_x_snap;
   logic [X_W:0]      cur_x;
   logic [Y_W:0]      cur_y;
   logic [IDX_W-1:0]  slot;
   logic [COL_W-1:0]  col;

   logic [X_W:0]      x_right;
   logic [Y_W:0]      y_bottom;
   logic [X_W:0]      px_ext;
   logic [Y_W:0]      py_ext;
   logic              slot_hit;
   logic              last_slot;
   logic              last_col;

   // Shared box comparator for the current slot; edges carry one extra bit so
   // a box hanging off the right/bottom of the screen never wraps to zero.
   always_comb begin
      x_right   = cur_x + (X_W+1)'(ALIEN_W - 1);
      y_bottom  = cur_y + (Y_W+1)'(ALIEN_H - 1);
      px_ext    = {1'b0, px_snap};
      py_ext    = {1'b0, py_snap};
      slot_hit  = alive_snap[slot]
                  && (px_ext >= cur_x) && (px_ext <= x_right)
                  && (py_ext >= cur_y) && (py_ext <= y_bottom);
      last_slot = (slot == IDX_W'(N - 1));
      last_col  = (col == COL_W'(COLS - 1));
   end

   // Scan FSM with registered outputs; the hit output doubles as the hit flag
   // because it is only ever set on the transition into DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         hit         <= 1'b0;
         hit_index   <= '0;
         alive_snap  <= '0;
         px_snap     <= '0;
         py_snap     <= '0;
         grid_x_snap <= '0;
         cur_x       <= '0;
         cur_y       <= '0;
         slot        <= '0;
         col         <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               done <= 1'b0;
               hit  <= 1'b0;
               if (clk_collision) begin
                  if (proj_valid) begin
                     alive_snap  <= alive;
                     px_snap     <= proj_x;
                     py_snap     <= proj_y;
                     grid_x_snap <= {1'b0, grid_x};
                     cur_x       <= {1'b0, grid_x};
                     cur_y       <= {1'b0, grid_y};
                     slot        <= '0;
                     col         <= '0;
                     busy        <= 1'b1;
                     state_reg   <= SCAN;
                  end else begin
                     // Nothing in flight: report an empty result right away.
                     done      <= 1'b1;
                     state_reg <= DONE;
                  end
               end
            end
            SCAN: begin
               if (slot_hit) begin
                  hit_index <= slot;
                  hit       <= 1'b1;
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  state_reg <= DONE;
               end else if (last_slot) begin
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  state_reg <= DONE;
               end else begin
                  slot <= slot + IDX_W'(1);
                  if (last_col) begin
                     col   <= '0;
                     cur_x <= grid_x_snap;
                     cur_y <= cur_y + (Y_W+1)'(SPACE_Y);
                  end else begin
                     col   <= col + COL_W'(1);
                     cur_x <= cur_x + (X_W+1)'(SPACE_X);
                  end
               end
            end
            DONE: begin
               done      <= 1'b0;
               hit       <= 1'b0;
               state_reg <= IDLE;
            end
            default: begin
               busy      <= 1'b0;
               done      <= 1'b0;
               hit       <= 1'b0;
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_collision_scheduler.sv
// tb_collision_scheduler: directed and randomized requests checked cycle by
// cycle against a timeline model whose scan result comes from a direct
// geometric search of the formation.
module tb_collision_scheduler;

   localparam int COLS    = 11;
   localparam int ROWS    = 5;
   localparam int N       = ROWS * COLS;
   localparam int X_W     = 10;
   localparam int Y_W     = 10;
   localparam int IDX_W   = 6;
   localparam int ALIEN_W = 16;
   localparam int ALIEN_H = 8;
   localparam int SPACE_X = 24;
   localparam int SPACE_Y = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic              clk_collision;
   logic [X_W-1:0]    grid_x;
   logic [Y_W-1:0]    grid_y;
   logic [N-1:0]      alive;
   logic              proj_valid;
   logic [X_W-1:0]    proj_x;
   logic [Y_W-1:0]    proj_y;
   logic              busy;
   logic              done;
   logic              hit;
   logic [IDX_W-1:0]  hit_index;

   always #5 clk = ~clk;

   collision_scheduler #(
      .COLS(COLS), .ROWS(ROWS), .X_W(X_W), .Y_W(Y_W), .IDX_W(IDX_W),
      .ALIEN_W(ALIEN_W), .ALIEN_H(ALIEN_H), .SPACE_X(SPACE_X), .SPACE_Y(SPACE_Y)
   ) dut (
      .clk(clk), .rst(rst), .clk_collision(clk_collision),
      .grid_x(grid_x), .grid_y(grid_y), .alive(alive),
      .proj_valid(proj_valid), .proj_x(proj_x), .proj_y(proj_y),
      .busy(busy), .done(done), .hit(hit), .hit_index(hit_index)
   );

   int tests = 0;
   int fails = 0;
   int edge_n = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (edge %0d)", nm, act, exp, edge_n);
      end
   endtask

   // First alive slot whose inclusive box holds (px,py), or -1.
   function automatic int scan_ref(input int gx, input int gy, input logic [N-1:0] al,
                                   input int px, input int py);
      for (int k = 0; k < N; k++) begin
         int x = gx + (k % COLS) * SPACE_X;
         int y = gy + (k / COLS) * SPACE_Y;
         if (al[k] && px >= x && px <= x + ALIEN_W - 1 && py >= y && py <= y + ALIEN_H - 1)
            return k;
      end
      return -1;
   endfunction

   // Timeline model: phase 0 idle, 1 scanning (countdown to result), 2 done.
   int               m_phase = 0;
   int               m_left  = 0;
   int               m_res   = -1;
   logic             m_busy  = 1'b0;
   logic             m_done  = 1'b0;
   logic             m_hit   = 1'b0;
   logic [IDX_W-1:0] m_idx   = '0;

   always @(posedge clk) begin
      edge_n++;
      if (rst) begin
         m_phase = 0; m_busy = 0; m_done = 0; m_hit = 0; m_idx = '0;
      end else begin
         m_done = 0;
         m_hit  = 0;
         case (m_phase)
            0: if (clk_collision) begin
               if (!proj_valid) begin
                  m_done  = 1;
                  m_phase = 2;
               end else begin
                  m_res   = scan_ref(int'(grid_x), int'(grid_y), alive, int'(proj_x), int'(proj_y));
                  m_left  = (m_res < 0) ? N - 1 : m_res;
                  m_busy  = 1;
                  m_phase = 1;
               end
            end
            1: if (m_left == 0) begin
               m_done  = 1;
               m_busy  = 0;
               m_phase = 2;
               if (m_res >= 0) begin
                  m_hit = 1;
                  m_idx = m_res[IDX_W-1:0];
               end
            end else begin
               m_left--;
            end
            default: m_phase = 0;
         endcase
      end
   end

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (edge_n > 0) begin
         check("busy", busy, m_busy);
         check("done", done, m_done);
         check("hit", hit, m_hit);
         check("hit_index", hit_index, m_idx);
      end
   end

   // Issue one request and wait for its done; returns at the done negedge.
   task automatic run_req(input string nm, input int exp_lat, input int exp_idx, input bit noise);
      int t;
      int d;
      int bc;
      logic hv;
      logic [IDX_W-1:0] hi;
      @(negedge clk);
      clk_collision = 1'b1;
      t = edge_n + 1;
      @(negedge clk);
      clk_collision = 1'b0;
      d = -1; bc = 0; hv = 0; hi = '0;
      for (int i = 0; i < 200 && d < 0; i++) begin
         if (i > 0) @(negedge clk);
         if (done) begin
            d = edge_n; hv = hit; hi = hit_index;
         end else begin
            if (busy) bc++;
            if (noise) begin
               clk_collision = ($urandom_range(0, 3) == 0);
               grid_x = X_W'($urandom);
               proj_x = X_W'($urandom);
               alive  = {$urandom, $urandom};
            end
         end
      end
      clk_collision = 1'b0;
      if (d < 0) begin
         check({nm, " timeout"}, 0, 1);
      end else begin
         check({nm, " latency"}, d - t + 1, exp_lat);
         check({nm, " busy cycles"}, bc, (exp_lat > 1) ? exp_lat - 1 : 0);
         check({nm, " hit"}, hv, (exp_idx >= 0) ? 1 : 0);
         if (exp_idx >= 0) check({nm, " hit_index"}, hi, exp_idx);
      end
      $display("[TB] %s: req edge %0d, done edge %0d, hit=%0d idx=%0d", nm, t, d, hv, hi);
   endtask

   task automatic set_inputs(input int gx, input int gy, input logic [N-1:0] al,
                             input bit pv, input int px, input int py);
      grid_x = X_W'(gx); grid_y = Y_W'(gy); alive = al;
      proj_valid = pv; proj_x = X_W'(px); proj_y = Y_W'(py);
   endtask

   function automatic int exp_latency(input bit pv, input int r);
      if (!pv) return 1;
      return (r < 0) ? N + 1 : r + 2;
   endfunction

   initial begin
      logic [N-1:0] all_alive;
      logic [N-1:0] al;
      int cnt;
      all_alive = '1;
      rst = 1'b1; clk_collision = 1'b1;
      set_inputs(100, 40, all_alive, 1, 177, 75);

      // Reset with a request pulse held active: both cycles must be ignored.
      repeat (2) @(negedge clk);
      check("reset busy", busy, 0);
      check("reset done", done, 0);
      check("reset hit", hit, 0);
      check("reset hit_index", hit_index, 0);
      rst = 1'b0; clk_collision = 1'b0;
      @(negedge clk);
      check("post-reset busy", busy, 0);

      // Hand-computed pins on the geometric reference itself.
      check("ref direct", scan_ref(100, 40, all_alive, 177, 75), 25);
      check("ref corner", scan_ref(100, 40, all_alive, 115, 47), 0);
      check("ref gap", scan_ref(100, 40, all_alive, 116, 40), 32'hFFFF_FFFF);
      al = all_alive; al[25] = 1'b0;
      check("ref dead", scan_ref(100, 40, al, 177, 75), 32'hFFFF_FFFF);

      // Directed scenarios with literal expectations.
      set_inputs(100, 40, all_alive, 1, 177, 75);
      run_req("direct hit", 27, 25, 0);
      set_inputs(100, 40, all_alive, 1, 115, 47);
      run_req("corner inclusive", 2, 0, 0);
      set_inputs(100, 40, all_alive, 1, 116, 40);
      run_req("column gap", 56, -1, 0);
      set_inputs(100, 40, al, 1, 177, 75);
      run_req("dead slot", 56, -1, 0);
      al[24:0] = '0;
      set_inputs(100, 40, al, 1, 177, 75);
      run_req("dead rows", 56, -1, 0);
      set_inputs(100, 40, all_alive, 0, 177, 75);
      run_req("no projectile", 1, -1, 0);

      // Extra pulses and moving inputs during a scan follow the snapshot.
      set_inputs(100, 40, all_alive, 1, 177, 75);
      run_req("noisy direct", 27, 25, 1);
      cnt = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (done) cnt++;
      end
      check("no extra done", cnt, 0);

      // Reset ten cycles into a scan abandons it silently.
      set_inputs(100, 40, all_alive, 1, 116, 40);
      @(negedge clk);
      clk_collision = 1'b1;
      @(negedge clk);
      clk_collision = 1'b0;
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midscan rst busy", busy, 0);
      check("midscan rst done", done, 0);
      cnt = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (done) cnt++;
      end
      check("abandoned scan done", cnt, 0);
      set_inputs(100, 40, all_alive, 1, 177, 75);
      run_req("after reset", 27, 25, 0);

      // Randomized requests against the reference.
      for (int it = 0; it < 40; it++) begin
         int gx, gy, s, px, py, r;
         bit pv;
         gx = $urandom_range(10, 700);
         gy = $urandom_range(10, 400);
         for (int k = 0; k < N; k++) al[k] = ($urandom_range(0, 9) < 8);
         pv = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 4) == 0) begin
            px = $urandom_range(0, 1023);
            py = $urandom_range(0, 1023);
         end else begin
            s  = $urandom_range(0, N - 1);
            px = gx + (s % COLS) * SPACE_X + $urandom_range(0, ALIEN_W + 3) - 2;
            py = gy + (s / COLS) * SPACE_Y + $urandom_range(0, ALIEN_H + 3) - 2;
         end
         set_inputs(gx, gy, al, pv, px, py);
         r = scan_ref(gx, gy, al, px, py);
         run_req($sformatf("random %0d", it), exp_latency(pv, r), pv ? r : -1, it[0]);
      end

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
